// File: rtl/mc_control_unit.sv
// mc_control_unit: main FSM, instruction/ALU decode and conditional execution
// for the multi-cycle 8-bit ARM-subset core.
// Ports: clk/reset; Op/Funct/Cond decoded fields and ALUFlags in; datapath
//   write enables, mux selects, ALUControl, ImmSrc, RegSrc and debug state out.
module mc_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [2:0] Cond,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       AluSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [2:0] RegSrc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_nzcv;      // {N,Z,C,V}
  logic       r_cond_ok;   // condition result captured at the end of DECODE

  logic [3:0] w_cmd;
  logic       w_cond_ex;
  logic       w_cmp;
  logic       w_nowrite;
  logic       w_exec;
  logic       w_flag_upd;
  logic [2:0] w_dp_alu;
  logic       w_pcw, w_regw, w_memw, w_irw;

  assign w_cmd = Funct[4:1];
  assign w_cmp = (w_cmd == 4'b1010);
  assign w_exec = (r_state == S_EXECUTER) || (r_state == S_EXECUTEI);

  // Condition check against the registered flags.
  always_comb begin
    w_cond_ex = 1'b1;
    case (Cond)
      3'b000:  w_cond_ex = r_nzcv[2];
      3'b001:  w_cond_ex = ~r_nzcv[2];
      3'b010:  w_cond_ex = r_nzcv[1];
      3'b011:  w_cond_ex = ~r_nzcv[1];
      3'b100:  w_cond_ex = r_nzcv[3];
      3'b101:  w_cond_ex = ~r_nzcv[3];
      3'b110:  w_cond_ex = (r_nzcv[3] == r_nzcv[0]);
      default: w_cond_ex = 1'b1;
    endcase
  end

  // ALU decode; unsupported commands and CMP never write the register file.
  always_comb begin
    w_dp_alu  = 3'b000;
    w_nowrite = 1'b0;
    case (w_cmd)
      4'b0100: w_dp_alu = 3'b000;
      4'b0010: w_dp_alu = 3'b001;
      4'b0000: w_dp_alu = 3'b010;
      4'b1100: w_dp_alu = 3'b011;
      4'b1010: begin w_dp_alu = 3'b001; w_nowrite = 1'b1; end
      default: begin w_dp_alu = 3'b000; w_nowrite = 1'b1; end
    endcase
  end

  // The flags only move at the end of EXECUTE, so the condition captured in
  // DECODE holds for the whole instruction; ALUWB must not see its own update.
  assign w_flag_upd = w_exec && r_cond_ok && (Funct[0] || w_cmp);

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          default: w_next = S_FETCH;
        endcase
      end
      S_EXECUTER, S_EXECUTEI: w_next = S_ALUWB;
      S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_nzcv    <= 4'b0000;
      r_cond_ok <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cond_ok <= w_cond_ex;
      if (w_flag_upd)          r_nzcv    <= ALUFlags;
    end
  end

  // Moore decode of selects and enables.
  always_comb begin
    w_pcw      = 1'b0;
    w_regw     = 1'b0;
    w_memw     = 1'b0;
    w_irw      = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    AluSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    ImmSrc     = 2'b00;
    RegSrc     = 3'b000;
    case (r_state)
      S_FETCH: begin
        w_irw = 1'b1; w_pcw = 1'b1;
        AluSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_DECODE: begin
        AluSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_EXECUTER: ALUControl = w_dp_alu;
      S_EXECUTEI: begin
        ALUSrcB = 2'b01; ALUControl = w_dp_alu;
      end
      S_ALUWB:  w_regw = r_cond_ok & ~w_nowrite;
      S_MEMADR: begin
        ALUSrcB = 2'b01; ImmSrc = 2'b01;
      end
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01; w_regw = r_cond_ok;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1; RegSrc = 3'b010; w_memw = r_cond_ok;
      end
      S_BRANCH: begin
        RegSrc = 3'b001; ALUSrcB = 2'b01; ImmSrc = 2'b10;
        ResultSrc = 2'b10; w_pcw = r_cond_ok;
      end
      default: ;
    endcase
  end

  // Reset blocks every write immediately, not just from the next edge.
  assign PCWrite  = w_pcw  & ~reset;
  assign RegWrite = w_regw & ~reset;
  assign MemWrite = w_memw & ~reset;
  assign IRWrite  = w_irw  & ~reset;
  assign state    = r_state;

endmodule
